// File: rtl/apb_master_bridge.sv
// Host-to-APB requester: turns single-word host requests into two-phase APB
// transfers on one of NUM_SLAVES slaves and returns a one-cycle response strobe.
module apb_master_bridge #(
   parameter int NUM_SLAVES = 2,
   parameter int SEL_LSB    = 12,
   parameter int SEL_W      = 1,
   parameter int TIMEOUT    = 1024
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       resp_valid,
   output logic [31:0]                resp_rdata,
   output logic                       resp_err,
   output logic [31:0]                PADDR,
   output logic [31:0]                PWDATA,
   output logic                       PWRITE,
   output logic [NUM_SLAVES-1:0]      PSELx,
   output logic                       PENABLE,
   input  logic [32*NUM_SLAVES-1:0]   PRDATA,
   input  logic [NUM_SLAVES-1:0]      PREADY,
   output logic [1:0]                 dbg_state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERR    = 2'd3;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [1:0]            state_q, state_d;
   logic [NUM_SLAVES-1:0] sel_q, sel_d;
   logic [31:0]           paddr_q, paddr_d;
   logic [31:0]           pwdata_q, pwdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;

   logic [SEL_W-1:0]      req_idx;
   logic [31:0]           req_idx_ext;
   logic [NUM_SLAVES-1:0] req_onehot;
   logic                  req_hit;
   logic                  ready_sel;
   logic [31:0]           rdata_sel;
   logic                  timeout_hit;

   // Decode to a one-hot select; indexes beyond NUM_SLAVES leave it all-zero.
   always_comb begin
      req_idx     = req_addr[SEL_LSB +: SEL_W];
      req_idx_ext = 32'(req_idx);
      req_onehot  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         req_onehot[i] = (req_idx_ext == 32'(i));
      end
      req_hit = |req_onehot;
   end

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) rdata_sel = rdata_sel | PRDATA[32*i +: 32];
      end
      ready_sel   = |(PREADY & sel_q);
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pwrite_d     = pwrite_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               paddr_d  = req_addr;
               pwrite_d = req_write;
               if (req_write) pwdata_d = req_wdata;
               if (req_hit) begin
                  sel_d   = req_onehot;
                  cnt_d   = '0;
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (ready_sel) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = pwrite_q ? 32'h0 : rdata_sel;
               state_d      = ST_IDLE;
            end else if (timeout_hit) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
               state_d      = ST_IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ERR: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pwrite_q     <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pwrite_q     <= pwrite_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Select is gated by state, so an async reset drops PSELx/PENABLE at once.
   assign PSELx      = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_q : '0;
   assign PENABLE    = (state_q == ST_ACCESS);
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign PWRITE     = pwrite_q;
   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign dbg_state  = state_q;

endmodule
